// File: rtl/vec_rf_pkg.sv
// Shared types and constants for the vector register file and its scoreboard.
// Latency: n/a (types only).
// Backpressure: n/a.
package vec_rf_pkg;

    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    // Entry hard-wired to zero when the zero-register option is enabled.
    localparam rf_addr_t RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic     en;
        rf_addr_t addr;
    } rd_req_t;

endpackage

// File: rtl/gen_reg.sv
// Generic pipeline register with synchronous active-high reset to zero.
// Latency: 1 cycle. Backpressure: none, the register loads every cycle.
// Ports: i_clk, i_rst, i_d (next value), o_q (registered value).
module gen_reg #(
    parameter int p_w = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [p_w-1:0] i_d,
    output logic [p_w-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst) o_q <= '0;
        else       o_q <= i_d;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: set on claim, cleared on writeback, two combinational queries.
// Latency: set/clear take effect after the edge; queries reflect current state.
// Backpressure: none. Ports: i_set_* claim, i_clr_* writeback clear, i_q*_addr/o_q*_busy queries.
module reg_scoreboard #(
    parameter int p_depth  = 32,
    parameter int p_addr_w = $clog2(p_depth)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_set_en,
    input  logic [p_addr_w-1:0] i_set_addr,
    input  logic                i_clr_en,
    input  logic [p_addr_w-1:0] i_clr_addr,
    input  logic [p_addr_w-1:0] i_qa_addr,
    input  logic [p_addr_w-1:0] i_qb_addr,
    output logic                o_qa_busy,
    output logic                o_qb_busy
);

    logic [p_depth-1:0] r_busy;

    // Set is checked first so a claim and a writeback to the same entry
    // leave it busy: the newer instruction still owns the destination.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < p_depth; i++) begin
                if (i_set_en && (i_set_addr == p_addr_w'(i)))
                    r_busy[i] <= 1'b1;
                else if (i_clr_en && (i_clr_addr == p_addr_w'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    // Out-of-range addresses match no entry and read as not busy.
    always_comb begin
        o_qa_busy = 1'b0;
        o_qb_busy = 1'b0;
        for (int i = 0; i < p_depth; i++) begin
            if (i_qa_addr == p_addr_w'(i)) o_qa_busy = r_busy[i];
            if (i_qb_addr == p_addr_w'(i)) o_qb_busy = r_busy[i];
        end
    end

endmodule

// File: rtl/vec_reg_file.sv
// Register file: one write port, two registered read ports, per-entry busy scoreboard.
// Latency: reads 1 cycle (data/busy/valid registered), write-to-read bypass in the same cycle.
// Backpressure: none; ports i_wr_*, i_claim_*, i_rd_*_a/b in, o_rd_data/valid/busy_a/b out.
module vec_reg_file
    import vec_rf_pkg::*;
#(
    parameter int p_width    = 32,
    parameter int p_depth    = 32,
    parameter int p_addr_w   = $clog2(p_depth),
    parameter int p_zero_reg = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [p_addr_w-1:0] i_wr_addr,
    input  logic [p_width-1:0]  i_wr_data,
    input  logic                i_claim_en,
    input  logic [p_addr_w-1:0] i_claim_addr,
    input  logic                i_rd_en_a,
    input  logic [p_addr_w-1:0] i_rd_addr_a,
    output logic [p_width-1:0]  o_rd_data_a,
    output logic                o_rd_valid_a,
    output logic                o_busy_a,
    input  logic                i_rd_en_b,
    input  logic [p_addr_w-1:0] i_rd_addr_b,
    output logic [p_width-1:0]  o_rd_data_b,
    output logic                o_rd_valid_b,
    output logic                o_busy_b
);

    logic [p_width-1:0] r_mem [p_depth];

    rd_req_t              w_req_a, w_req_b;
    logic                 w_wr_ok, w_claim_ok;
    logic                 w_sb_busy_a, w_sb_busy_b;
    logic [p_width:0]     w_rd_a, w_rd_b;
    logic [p_width+1:0]   w_stg_d_a, w_stg_d_b;
    logic [p_width+1:0]   w_stg_q_a, w_stg_q_b;

    // An entry is live when it exists and is not the hard-wired zero entry.
    function automatic logic f_live(input logic [p_addr_w-1:0] a);
        return (int'(a) < p_depth) &&
               !((p_zero_reg != 0) && (a == p_addr_w'(RF_ZERO_ADDR)));
    endfunction

    // Returns {busy, data} for one read port. A same-cycle write to the
    // same entry is forwarded and shows the entry as free; a same-cycle
    // claim is only visible from the next cycle on.
    function automatic logic [p_width:0] f_rd(input logic [p_addr_w-1:0] a,
                                              input logic               sb_busy);
        logic [p_width-1:0] d;
        logic               b;
        d = '0;
        b = 1'b0;
        if (w_wr_ok && (a == i_wr_addr)) begin
            d = i_wr_data;
        end else if (f_live(a)) begin
            for (int i = 0; i < p_depth; i++)
                if (a == p_addr_w'(i)) d = r_mem[i];
            b = sb_busy;
        end
        return {b, d};
    endfunction

    assign w_req_a    = '{en: i_rd_en_a, addr: rf_addr_t'(i_rd_addr_a)};
    assign w_req_b    = '{en: i_rd_en_b, addr: rf_addr_t'(i_rd_addr_b)};
    assign w_wr_ok    = i_wr_en    && f_live(i_wr_addr);
    assign w_claim_ok = i_claim_en && f_live(i_claim_addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < p_depth; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < p_depth; i++)
                if (w_wr_ok && (i_wr_addr == p_addr_w'(i))) r_mem[i] <= i_wr_data;
        end
    end

    reg_scoreboard #(
        .p_depth  (p_depth),
        .p_addr_w (p_addr_w)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (w_claim_ok),
        .i_set_addr (i_claim_addr),
        .i_clr_en   (w_wr_ok),
        .i_clr_addr (i_wr_addr),
        .i_qa_addr  (p_addr_w'(w_req_a.addr)),
        .i_qb_addr  (p_addr_w'(w_req_b.addr)),
        .o_qa_busy  (w_sb_busy_a),
        .o_qb_busy  (w_sb_busy_b)
    );

    assign w_rd_a = f_rd(p_addr_w'(w_req_a.addr), w_sb_busy_a);
    assign w_rd_b = f_rd(p_addr_w'(w_req_b.addr), w_sb_busy_b);

    // Idle ports recirculate data/busy so they hold; only valid drops.
    assign w_stg_d_a = w_req_a.en ? {1'b1, w_rd_a} : {1'b0, o_busy_a, o_rd_data_a};
    assign w_stg_d_b = w_req_b.en ? {1'b1, w_rd_b} : {1'b0, o_busy_b, o_rd_data_b};

    gen_reg #(.p_w(p_width + 2)) u_stg_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (w_stg_d_a),
        .o_q   (w_stg_q_a)
    );

    gen_reg #(.p_w(p_width + 2)) u_stg_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (w_stg_d_b),
        .o_q   (w_stg_q_b)
    );

    assign {o_rd_valid_a, o_busy_a, o_rd_data_a} = w_stg_q_a;
    assign {o_rd_valid_b, o_busy_b, o_rd_data_b} = w_stg_q_b;

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file: reset, reads, writes, bypass, claims, zero entry, mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_vec_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        rd_en_a, rd_en_b;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_reg_file dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_claim_en   (claim_en),
        .i_claim_addr (claim_addr),
        .i_rd_en_a    (rd_en_a),
        .i_rd_addr_a  (rd_addr_a),
        .o_rd_data_a  (rd_data_a),
        .o_rd_valid_a (rd_valid_a),
        .o_busy_a     (busy_a),
        .i_rd_en_b    (rd_en_b),
        .i_rd_addr_b  (rd_addr_b),
        .o_rd_data_b  (rd_data_b),
        .o_rd_valid_b (rd_valid_b),
        .o_busy_b     (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; claim_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic do_claim(input logic [4:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    task automatic do_rd_a(input logic [4:0] a);
        rd_en_a = 1'b1; rd_addr_a = a;
    endtask

    task automatic do_rd_b(input logic [4:0] a);
        rd_en_b = 1'b1; rd_addr_b = a;
    endtask

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; claim_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
        #1;

        // Reset
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
        chk("rst_data_a",  rd_data_a, 32'd0);
        chk("rst_busy_b",  32'(busy_b), 32'd0);

        // Read of freshly reset entries
        do_rd_a(5'd5); do_rd_b(5'd31); tick();
        chk("rd5_data",   rd_data_a, 32'd0);
        chk("rd31_data",  rd_data_b, 32'd0);
        chk("rd5_valid",  32'(rd_valid_a), 32'd1);
        chk("rd31_valid", 32'(rd_valid_b), 32'd1);
        chk("rd5_busy",   32'(busy_a), 32'd0);
        chk("rd31_busy",  32'(busy_b), 32'd0);

        // Plain write, later read
        do_write(5'd7, 32'hDEADBEEF); tick();
        chk("idle_valid_a", 32'(rd_valid_a), 32'd0);
        do_rd_a(5'd7); tick();
        chk("rd7_data",  rd_data_a, 32'hDEADBEEF);
        chk("rd7_valid", 32'(rd_valid_a), 32'd1);
        chk("rd7_busy",  32'(busy_a), 32'd0);
        tick();
        chk("hold_valid_a", 32'(rd_valid_a), 32'd0);
        chk("hold_data_a",  rd_data_a, 32'hDEADBEEF);

        // Write/read bypass
        do_write(5'd3, 32'h0000_1234); do_rd_a(5'd3); tick();
        chk("byp3_data", rd_data_a, 32'h0000_1234);
        chk("byp3_busy", 32'(busy_a), 32'd0);

        // Claim, then claim + write to the same entry
        do_claim(5'd9); tick();
        do_rd_b(5'd9); tick();
        chk("clm9_busy", 32'(busy_b), 32'd1);
        do_write(5'd9, 32'h0000_00AA); do_claim(5'd9); tick();
        do_rd_b(5'd9); tick();
        chk("cw9_data", rd_data_b, 32'h0000_00AA);
        chk("cw9_busy", 32'(busy_b), 32'd1);

        // A same-cycle claim is not seen by that read, only by the next one
        do_claim(5'd10); do_rd_a(5'd10); tick();
        chk("clm10_same_busy", 32'(busy_a), 32'd0);
        do_rd_a(5'd10); tick();
        chk("clm10_next_busy", 32'(busy_a), 32'd1);

        // Writeback to a busy entry, read in the same cycle: bypass shows it free
        do_write(5'd10, 32'hCAFE_F00D); do_rd_a(5'd10); do_rd_b(5'd10); tick();
        chk("wb10_data_a", rd_data_a, 32'hCAFE_F00D);
        chk("wb10_busy_a", 32'(busy_a), 32'd0);
        chk("wb10_busy_b", 32'(busy_b), 32'd0);
        do_rd_b(5'd10); tick();
        chk("wb10_after_busy", 32'(busy_b), 32'd0);

        // Zero entry ignores writes and claims and is never forwarded
        do_write(5'd0, 32'hFFFF_FFFF); do_claim(5'd0); tick();
        do_rd_a(5'd0); tick();
        chk("zr_data", rd_data_a, 32'd0);
        chk("zr_busy", 32'(busy_a), 32'd0);
        do_write(5'd0, 32'hFFFF_FFFF); do_rd_b(5'd0); tick();
        chk("zr_nobyp_data", rd_data_b, 32'd0);

        // Both ports read the same entry; full-width data pattern on port B
        do_rd_a(5'd7); do_rd_b(5'd7); tick();
        chk("dual7_a", rd_data_a, 32'hDEADBEEF);
        chk("dual7_b", rd_data_b, 32'hDEADBEEF);
        do_write(5'd31, 32'h8000_0001); tick();
        do_rd_b(5'd31); tick();
        chk("rd31_bits", rd_data_b, 32'h8000_0001);

        // Reset during a read drops it and clears storage
        do_write(5'd4, 32'h0000_0055); tick();
        do_rd_a(5'd4); rst = 1'b1; tick();
        chk("rstrd_valid", 32'(rd_valid_a), 32'd0);
        chk("rstrd_data",  rd_data_a, 32'd0);
        do_rd_a(5'd4); do_rd_b(5'd9); tick();
        chk("rerd4_data",  rd_data_a, 32'd0);
        chk("rerd4_valid", 32'(rd_valid_a), 32'd1);
        chk("rerd9_busy",  32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
